os_skew_feeder: RTL and testbench
=================================

OS_SKEW_FEEDER -- requirements
Module: os_skew_feeder

Interface
REQ-001 The block SHALL have parameter ROW_len, default 3, meaning array rows.
REQ-002 The block SHALL have parameter COL_len, default 3, meaning array columns.
REQ-003 The block SHALL have parameter K_len, default 3, meaning the shared inner dimension of A (ROW_len x K_len) and B (K_len x COL_len).
REQ-004 The block SHALL have parameter DW, default 8, meaning signed operand width.
REQ-005 The block SHALL have parameter AW, default 8, meaning write-address width.
REQ-006 The block SHALL have parameter DRAIN_CYC, default 1, meaning the number of compute_en cycles held after the last skew beat.
REQ-007 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-008 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-009 The block SHALL have port wr_en, input, 1 bit: operand buffer write strobe.
REQ-010 The block SHALL have port wr_sel, input, 1 bit: 0 selects the A buffer, 1 selects the B buffer.
REQ-011 The block SHALL have port wr_addr, input, AW bits: A[i][k] at address i*K_len+k, B[k][j] at address k*COL_len+j.
REQ-012 The block SHALL have port wr_data, input, DW bits, signed operand.
REQ-013 The block SHALL have port start, input, 1 bit: launches one matrix product.
REQ-014 The block SHALL have port a_bus, output, ROW_len*DW bits, registered: row i occupies bits [(i+1)*DW-1 -: DW].
REQ-015 The block SHALL have port b_bus, output, COL_len*DW bits, registered: column j occupies bits [(j+1)*DW-1 -: DW].
REQ-016 The block SHALL have ports compute_en and read_en_out, outputs, 1 bit each, registered: they drive the array's compute_en and read_en_in.
REQ-017 The block SHALL have ports busy and done, outputs, 1 bit each: busy high outside IDLE; done is a 1-cycle completion pulse.

Function
REQ-018 The FSM SHALL have states IDLE, FEED, DRAIN, READ and DONE.
REQ-019 Transitions SHALL be: IDLE->FEED on start; FEED->DRAIN after T = K_len+ROW_len+COL_len-2 beats; DRAIN->READ after DRAIN_CYC cycles; READ->DONE after ROW_len cycles; DONE->IDLE after 1 cycle.
REQ-020 On beat t of FEED (t = 0..T-1), row i of a_bus SHALL carry A[i][t-i] when 0 <= t-i < K_len, else 0.
REQ-021 On beat t of FEED, column j of b_bus SHALL carry B[t-j][j] when 0 <= t-j < K_len, else 0.
REQ-022 Beat 0 SHALL appear on the outputs in the cycle after the edge that samples start.
REQ-023 compute_en SHALL be 1 for exactly the T FEED beats plus the DRAIN_CYC DRAIN cycles, and 0 otherwise.
REQ-024 a_bus and b_bus SHALL be 0 outside FEED.
REQ-025 read_en_out SHALL be 1 for exactly ROW_len consecutive cycles, during READ only.
REQ-026 done SHALL pulse high for 1 cycle, in DONE, which follows the last READ cycle.
REQ-027 A write SHALL be accepted only when busy=0 and the address is in range (< ROW_len*K_len for A, < K_len*COL_len for B); all other writes SHALL be dropped silently.
REQ-028 If wr_en and start are both high in IDLE on the same edge, the write SHALL land before the launch, so the product uses the new value.
REQ-029 start SHALL be ignored while busy=1.
REQ-030 Buffer contents SHALL persist across runs, so a repeated start without writes reproduces identical streams.
REQ-031 Operands SHALL pass through bit-exact, with no sign extension or arithmetic.

Reset
REQ-032 While rst=1, the block SHALL go to IDLE and drive a_bus, b_bus, compute_en, read_en_out, busy and done to 0, regardless of the current state.
REQ-033 Reset SHALL clear all beat and row counters.
REQ-034 Reset SHALL leave operand buffer contents undefined.
REQ-035 After rst deasserts mid-run, the block SHALL not resume the run and SHALL wait in IDLE for a new start.

Verification
REQ-036 Defaults, A = [[1,2,3],[4,5,6],[7,8,9]], B = identity, start: FEED SHALL last 7 cycles. On beat 0, a_bus row0 = 1 and rows 1-2 = 0. On beat 2, a_bus rows = {3,5,7}. On beat 6, all rows = 0 except row2 = 9 at beat 4. compute_en SHALL be high for 8 cycles.
REQ-037 Same run: read_en_out SHALL be high for 3 cycles starting 8 cycles after beat 0. done SHALL pulse on the next cycle. busy SHALL fall with it.
REQ-038 start pulsed during FEED: no restart; beat count stays 7; exactly one done.
REQ-039 wr_en with wr_sel=0, wr_addr=9 (out of range) in IDLE, and any write while busy: A readback via the next run SHALL be unchanged.
REQ-040 rst=1 on beat 3 of FEED: outputs SHALL go to 0 in the same cycle. After release, the block SHALL stay idle. A new start SHALL produce a full 7-beat sequence.
REQ-041 ROW_len=2, COL_len=4, K_len=1: T SHALL be 5; b_bus column3 SHALL be nonzero only on beat 3.

Source files
------------

// File: rtl/os_skew_feeder.sv
// Operand skew feeder for an output-stationary systolic array: buffers A and B,
// then streams them diagonally (row i / column j delayed by i / j beats).
module os_skew_feeder #(
    parameter int ROW_len   = 3,
    parameter int COL_len   = 3,
    parameter int K_len     = 3,
    parameter int DW        = 8,
    parameter int AW        = 8,
    parameter int DRAIN_CYC = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic                    wr_sel,
    input  logic [AW-1:0]           wr_addr,
    input  logic [DW-1:0]           wr_data,
    input  logic                    start,
    output logic [ROW_len*DW-1:0]   a_bus,
    output logic [COL_len*DW-1:0]   b_bus,
    output logic                    compute_en,
    output logic                    read_en_out,
    output logic                    busy,
    output logic                    done
);

    localparam int T       = K_len + ROW_len + COL_len - 2;
    localparam int A_DEPTH = ROW_len * K_len;
    localparam int B_DEPTH = K_len * COL_len;
    localparam int A_IW    = (A_DEPTH > 1) ? $clog2(A_DEPTH) : 1;
    localparam int B_IW    = (B_DEPTH > 1) ? $clog2(B_DEPTH) : 1;
    localparam int CW      = 16;
    localparam logic [AW:0] A_LIM = (AW+1)'(A_DEPTH);
    localparam logic [AW:0] B_LIM = (AW+1)'(B_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_FEED, S_DRAIN, S_READ, S_DONE} state_t;

    state_t                 r_state;
    logic [CW-1:0]          r_cnt;
    logic [ROW_len*DW-1:0]  r_a_bus;
    logic [COL_len*DW-1:0]  r_b_bus;
    logic                   r_compute_en;
    logic                   r_read_en;
    logic                   r_busy;
    logic                   r_done;

    logic [DW-1:0]          r_a_mem [0:A_DEPTH-1];
    logic [DW-1:0]          r_b_mem [0:B_DEPTH-1];

    logic                   w_wr_a;
    logic                   w_wr_b;
    logic [CW-1:0]          w_t;
    logic [ROW_len*DW-1:0]  w_a_next;
    logic [COL_len*DW-1:0]  w_b_next;

    assign w_wr_a = wr_en && !wr_sel && (r_state == S_IDLE) && ({1'b0, wr_addr} < A_LIM);
    assign w_wr_b = wr_en &&  wr_sel && (r_state == S_IDLE) && ({1'b0, wr_addr} < B_LIM);

    always_ff @(posedge clk) begin
        if (w_wr_a) r_a_mem[A_IW'(wr_addr)] <= wr_data;
        if (w_wr_b) r_b_mem[B_IW'(wr_addr)] <= wr_data;
    end

    // Beat to be registered at the coming edge: 0 at launch, else one past the shown beat.
    assign w_t = (r_state == S_FEED) ? r_cnt + CW'(1) : '0;

    genvar gi;
    generate
        for (gi = 0; gi < ROW_len; gi++) begin : g_row
            logic [A_IW-1:0] w_idx;
            logic [DW-1:0]   w_val;
            always_comb begin
                w_idx = '0;
                w_val = '0;
                if (int'(w_t) >= gi && int'(w_t) < gi + K_len) begin
                    w_idx = A_IW'(gi * K_len + int'(w_t) - gi);
                    // A write coinciding with start must be visible on beat 0.
                    w_val = (w_wr_a && A_IW'(wr_addr) == w_idx) ? wr_data : r_a_mem[w_idx];
                end
            end
            assign w_a_next[(gi+1)*DW-1 -: DW] = w_val;
        end

        for (gi = 0; gi < COL_len; gi++) begin : g_col
            logic [B_IW-1:0] w_idx;
            logic [DW-1:0]   w_val;
            always_comb begin
                w_idx = '0;
                w_val = '0;
                if (int'(w_t) >= gi && int'(w_t) < gi + K_len) begin
                    w_idx = B_IW'((int'(w_t) - gi) * COL_len + gi);
                    w_val = (w_wr_b && B_IW'(wr_addr) == w_idx) ? wr_data : r_b_mem[w_idx];
                end
            end
            assign w_b_next[(gi+1)*DW-1 -: DW] = w_val;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_a_bus      <= '0;
            r_b_bus      <= '0;
            r_compute_en <= 1'b0;
            r_read_en    <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state      <= S_FEED;
                        r_cnt        <= '0;
                        r_a_bus      <= w_a_next;
                        r_b_bus      <= w_b_next;
                        r_compute_en <= 1'b1;
                        r_busy       <= 1'b1;
                    end
                end
                S_FEED: begin
                    if (r_cnt == CW'(T - 1)) begin
                        r_a_bus <= '0;
                        r_b_bus <= '0;
                        r_cnt   <= '0;
                        if (DRAIN_CYC == 0) begin
                            r_state      <= S_READ;
                            r_compute_en <= 1'b0;
                            r_read_en    <= 1'b1;
                        end else begin
                            r_state <= S_DRAIN;
                        end
                    end else begin
                        r_cnt   <= r_cnt + CW'(1);
                        r_a_bus <= w_a_next;
                        r_b_bus <= w_b_next;
                    end
                end
                S_DRAIN: begin
                    if (r_cnt == CW'(DRAIN_CYC - 1)) begin
                        r_state      <= S_READ;
                        r_cnt        <= '0;
                        r_compute_en <= 1'b0;
                        r_read_en    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_READ: begin
                    if (r_cnt == CW'(ROW_len - 1)) begin
                        r_state   <= S_DONE;
                        r_cnt     <= '0;
                        r_read_en <= 1'b0;
                        r_done    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign a_bus       = r_a_bus;
    assign b_bus       = r_b_bus;
    assign compute_en  = r_compute_en;
    assign read_en_out = r_read_en;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule

// File: tb/tb_os_skew_feeder.sv
// Bench for os_skew_feeder: directed and random matrices checked cycle by cycle
// against a matrix-level model of the skewed streams and control timing.
module tb_os_skew_feeder;

    localparam int R = 3, C = 3, K = 3, D = 1;
    localparam int T = K + R + C - 2;
    localparam int SR = 2, SC = 4, SK = 1;
    localparam int ST = SK + SR + SC - 2;

    logic clk = 1'b0;
    logic rst;
    logic wr_en, wr_sel, start;
    logic [7:0] wr_addr, wr_data;
    logic [R*8-1:0] a_bus;
    logic [C*8-1:0] b_bus;
    logic compute_en, read_en_out, busy, done;

    logic s_wr_en, s_wr_sel, s_start;
    logic [7:0] s_wr_addr, s_wr_data;
    logic [SR*8-1:0] s_a_bus;
    logic [SC*8-1:0] s_b_bus;
    logic s_compute_en, s_read_en_out, s_busy, s_done;

    int checks = 0;
    int errors = 0;

    logic [7:0] ma [0:R-1][0:K-1];
    logic [7:0] mb [0:K-1][0:C-1];
    logic [7:0] sa [0:SR-1];
    logic [7:0] sb [0:SC-1];
    logic [R*8-1:0] cap_a [0:63];

    always #5 clk = ~clk;

    os_skew_feeder u_dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start), .a_bus(a_bus), .b_bus(b_bus),
        .compute_en(compute_en), .read_en_out(read_en_out), .busy(busy), .done(done)
    );

    os_skew_feeder #(.ROW_len(SR), .COL_len(SC), .K_len(SK)) u_small (
        .clk(clk), .rst(rst), .wr_en(s_wr_en), .wr_sel(s_wr_sel), .wr_addr(s_wr_addr),
        .wr_data(s_wr_data), .start(s_start), .a_bus(s_a_bus), .b_bus(s_b_bus),
        .compute_en(s_compute_en), .read_en_out(s_read_en_out), .busy(s_busy), .done(s_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [R*8-1:0] exp_a(input int t);
        logic [R*8-1:0] r = '0;
        for (int i = 0; i < R; i++)
            if (t - i >= 0 && t - i < K) r[i*8 +: 8] = ma[i][t-i];
        return r;
    endfunction

    function automatic logic [C*8-1:0] exp_b(input int t);
        logic [C*8-1:0] r = '0;
        for (int j = 0; j < C; j++)
            if (t - j >= 0 && t - j < K) r[j*8 +: 8] = mb[t-j][j];
        return r;
    endfunction

    task automatic wr(input logic sel, input logic [7:0] addr, input logic [7:0] data);
        wr_en = 1'b1; wr_sel = sel; wr_addr = addr; wr_data = data;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic load(input bit directed);
        for (int i = 0; i < R; i++)
            for (int k = 0; k < K; k++) begin
                ma[i][k] = directed ? 8'(i*K + k + 1) : 8'($urandom);
                wr(1'b0, 8'(i*K + k), ma[i][k]);
            end
        for (int k = 0; k < K; k++)
            for (int j = 0; j < C; j++) begin
                mb[k][j] = directed ? ((k == j) ? 8'd1 : 8'd0) : 8'($urandom);
                wr(1'b1, 8'(k*C + j), mb[k][j]);
            end
    endtask

    // One product launched now; start_at/wr_at inject start/write pulses while busy,
    // co_addr >= 0 writes A[co_addr] on the launching edge.
    task automatic run_main(input string name, input int start_at, input int wr_at,
                            input int co_addr, input logic [7:0] co_data);
        start = 1'b1;
        if (co_addr >= 0) begin
            wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 8'(co_addr); wr_data = co_data;
            ma[co_addr / K][co_addr % K] = co_data;
        end
        tick();
        start = 1'b0; wr_en = 1'b0;
        for (int c = 0; c <= T + D + R + 2; c++) begin
            chk($sformatf("%s_c%0d_a", name, c), 64'(a_bus), 64'((c < T) ? exp_a(c) : '0));
            chk($sformatf("%s_c%0d_b", name, c), 64'(b_bus), 64'((c < T) ? exp_b(c) : '0));
            chk($sformatf("%s_c%0d_ce", name, c), 64'(compute_en), 64'(c < T + D));
            chk($sformatf("%s_c%0d_re", name, c), 64'(read_en_out), 64'(c >= T + D && c < T + D + R));
            chk($sformatf("%s_c%0d_done", name, c), 64'(done), 64'(c == T + D + R));
            chk($sformatf("%s_c%0d_busy", name, c), 64'(busy), 64'(c <= T + D + R));
            cap_a[c] = a_bus;
            start   = (c == start_at);
            wr_en   = (c == wr_at);
            wr_sel  = 1'b0; wr_addr = 8'd0; wr_data = 8'hAA;
            tick();
        end
        start = 1'b0; wr_en = 1'b0;
    endtask

    task automatic chk_quiet(input string name);
        chk({name, "_a"}, 64'(a_bus), 64'd0);
        chk({name, "_b"}, 64'(b_bus), 64'd0);
        chk({name, "_ce"}, 64'(compute_en), 64'd0);
        chk({name, "_re"}, 64'(read_en_out), 64'd0);
        chk({name, "_busy"}, 64'(busy), 64'd0);
        chk({name, "_done"}, 64'(done), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n3, beat3;
        logic [SC*8-1:0] eb;
        logic [SR*8-1:0] ea;
        rst = 1'b1; wr_en = 0; wr_sel = 0; wr_addr = 0; wr_data = 0; start = 0;
        s_wr_en = 0; s_wr_sel = 0; s_wr_addr = 0; s_wr_data = 0; s_start = 0;
        tick(); tick();
        chk_quiet("reset");
        rst = 1'b0;
        tick();

        // Directed matrices: A = 1..9, B = identity.
        load(1'b1);
        run_main("dir", -1, -1, -1, 8'h00);
        chk("dir_beat0", 64'(cap_a[0]), 64'h000001);
        chk("dir_beat2", 64'(cap_a[2]), 64'h070503);
        chk("dir_beat4", 64'(cap_a[4]), 64'h090000);
        chk("dir_beat6", 64'(cap_a[6]), 64'h000000);

        // Random matrices, run twice for persistence, then with start pulsed during FEED.
        load(1'b0);
        run_main("rnd1", -1, -1, -1, 8'h00);
        run_main("rnd2", -1, -1, -1, 8'h00);
        run_main("restart", 3, -1, -1, 8'h00);

        // Dropped writes: out of range in IDLE and any write while busy.
        wr(1'b0, 8'd9, 8'h55);
        wr(1'b1, 8'd9, 8'h66);
        run_main("busywr", -1, 4, -1, 8'h00);
        run_main("readback", -1, -1, -1, 8'h00);

        // Write on the launching edge must be used by that product.
        run_main("cowr", -1, -1, 0, 8'($urandom_range(1, 255)) ^ ma[0][0]);

        // Reset on beat 3 of FEED.
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        #1;
        chk_quiet("midrst");
        tick();
        rst = 1'b0;
        tick(); tick(); tick();
        chk_quiet("postrst");
        load(1'b0);
        run_main("afterrst", -1, -1, -1, 8'h00);

        // Narrow configuration: 2x1 by 1x4.
        for (int i = 0; i < SR; i++) begin
            sa[i] = 8'($urandom_range(1, 255));
            s_wr_en = 1; s_wr_sel = 0; s_wr_addr = 8'(i); s_wr_data = sa[i];
            tick();
        end
        for (int j = 0; j < SC; j++) begin
            sb[j] = 8'($urandom_range(1, 255));
            s_wr_en = 1; s_wr_sel = 1; s_wr_addr = 8'(j); s_wr_data = sb[j];
            tick();
        end
        s_wr_en = 0;
        s_start = 1; tick(); s_start = 0;
        n3 = 0; beat3 = -1;
        for (int c = 0; c <= ST + D + SR + 2; c++) begin
            ea = '0; eb = '0;
            for (int i = 0; i < SR; i++) if (c < ST && c == i) ea[i*8 +: 8] = sa[i];
            for (int j = 0; j < SC; j++) if (c < ST && c == j) eb[j*8 +: 8] = sb[j];
            chk($sformatf("small_c%0d_a", c), 64'(s_a_bus), 64'(ea));
            chk($sformatf("small_c%0d_b", c), 64'(s_b_bus), 64'(eb));
            chk($sformatf("small_c%0d_ce", c), 64'(s_compute_en), 64'(c < ST + D));
            chk($sformatf("small_c%0d_re", c), 64'(s_read_en_out), 64'(c >= ST + D && c < ST + D + SR));
            chk($sformatf("small_c%0d_done", c), 64'(s_done), 64'(c == ST + D + SR));
            if (s_b_bus[31:24] != 8'd0) begin
                n3++;
                beat3 = c;
            end
            tick();
        end
        chk("small_col3_count", 64'(n3), 64'd1);
        chk("small_col3_beat", 64'(beat3), 64'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
